// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (C) and loader (L).
// Core has priority from idle; a bounded burst counter keeps either port from starving the other.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          m_wr_en,
    output logic          m_rd_en,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          core_stall
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        LDR  = 2'd2
    } owner_t;

    owner_t        owner, owner_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          burst_left;

    assign burst_left = (burst_cnt < BURST_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= IDLE;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // The owner keeps the port while it asks, unless the other side is waiting
    // and the owner has already used its full burst.
    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        owner_nxt = IDLE;
        burst_nxt = '0;
        if (reset) begin
            case (owner)
                IDLE: begin
                    if (c_req)      c_gnt = 1'b1;
                    else if (l_req) l_gnt = 1'b1;
                end
                CORE: begin
                    if (c_req && (!l_req || burst_left)) c_gnt = 1'b1;
                    else if (l_req)                      l_gnt = 1'b1;
                end
                LDR: begin
                    if (l_req && (!c_req || burst_left)) l_gnt = 1'b1;
                    else if (c_req)                      c_gnt = 1'b1;
                end
                default: ;
            endcase
        end
        if (c_gnt) begin
            owner_nxt = CORE;
            if (owner != CORE)   burst_nxt = BURST_ONE;
            else if (burst_left) burst_nxt = burst_cnt + BURST_ONE;
            else                 burst_nxt = burst_cnt;
        end else if (l_gnt) begin
            owner_nxt = LDR;
            if (owner != LDR)    burst_nxt = BURST_ONE;
            else if (burst_left) burst_nxt = burst_cnt + BURST_ONE;
            else                 burst_nxt = burst_cnt;
        end
    end

    always_comb begin
        m_wr_en = 1'b0;
        m_rd_en = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_wr_en = c_we;
            m_rd_en = ~c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (l_gnt) begin
            m_wr_en = l_we;
            m_rd_en = ~l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    assign core_stall = c_req & ~c_gnt;

    // Memory read is combinational, so load data is captured at the grant edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            l_rvalid <= l_gnt & ~l_we;
            if (c_gnt && !c_we) c_rdata <= m_rdata;
            if (l_gnt && !l_we) l_rdata <= m_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// rule-level reference model with its own copy of the memory contents.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [DW-1:0] c_rdata, l_rdata;
    logic          m_wr_en, m_rd_en, core_stall;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .core_stall(core_stall)
    );

    always #5 clk = ~clk;

    // Memory the DUT talks to
    logic [DW-1:0] mem [256];
    assign m_rdata = mem[m_addr];
    always @(posedge clk) if (m_wr_en) mem[m_addr] <= m_wdata;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=core 2=loader, run = consecutive grants
    logic [DW-1:0] ref_mem [256];
    int            m_owner = 0, m_run = 0;
    bit            e_c, e_l;
    bit            e_crv = 0, e_lrv = 0;
    logic [DW-1:0] e_crd = '0, e_lrd = '0;
    bit            obs_c, obs_l;

    function automatic void model_grant();
        bit own_req, oth_req;
        e_c = 0;
        e_l = 0;
        if (!rst) return;
        if (m_owner == 0) begin
            if (c_req) e_c = 1; else if (l_req) e_l = 1;
        end else begin
            own_req = (m_owner == 1) ? c_req : l_req;
            oth_req = (m_owner == 1) ? l_req : c_req;
            if (own_req && (!oth_req || m_run < MB)) begin
                if (m_owner == 1) e_c = 1; else e_l = 1;
            end else if (oth_req) begin
                if (m_owner == 1) e_l = 1; else e_c = 1;
            end
        end
    endfunction

    function automatic void model_update();
        if (!rst) begin
            m_owner = 0; m_run = 0;
            e_crv = 0; e_lrv = 0; e_crd = '0; e_lrd = '0;
            return;
        end
        e_crv = e_c && !c_we;
        e_lrv = e_l && !l_we;
        if (e_crv) e_crd = ref_mem[c_addr];
        if (e_lrv) e_lrd = ref_mem[l_addr];
        if (e_c && c_we) ref_mem[c_addr] = c_wdata;
        if (e_l && l_we) ref_mem[l_addr] = l_wdata;
        if (e_c) begin
            m_run = (m_owner == 1) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
            m_owner = 1;
        end else if (e_l) begin
            m_run = (m_owner == 2) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
            m_owner = 2;
        end else begin
            m_owner = 0; m_run = 0;
        end
    endfunction

    // Inputs already driven; check this cycle, then advance one edge.
    task automatic tick();
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        #1;
        model_grant();
        ea = e_c ? c_addr : (e_l ? l_addr : '0);
        ew = e_c ? c_wdata : (e_l ? l_wdata : '0);
        check("c_gnt", c_gnt, e_c);
        check("l_gnt", l_gnt, e_l);
        check("m_wr_en", m_wr_en, (e_c && c_we) || (e_l && l_we));
        check("m_rd_en", m_rd_en, (e_c && !c_we) || (e_l && !l_we));
        check("m_addr", m_addr, ea);
        check("m_wdata", m_wdata, ew);
        check("core_stall", core_stall, c_req && !e_c);
        check("c_rvalid", c_rvalid, e_crv);
        check("c_rdata", c_rdata, e_crd);
        check("l_rvalid", l_rvalid, e_lrv);
        check("l_rdata", l_rdata, e_lrd);
        obs_c = c_gnt;
        obs_l = l_gnt;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_c(input bit r, input bit w, input int a, input int d);
        c_req = r; c_we = w; c_addr = AW'(a); c_wdata = DW'(d);
    endtask

    task automatic set_l(input bit r, input bit w, input int a, input int d);
        l_req = r; l_we = w; l_addr = AW'(a); l_wdata = DW'(d);
    endtask

    initial begin
        bit pat_c [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset held with both requesting, then release
        set_c(1, 0, 8'h01, 0);
        set_l(1, 0, 8'h02, 0);
        tick();
        tick();
        check("rst_c_gnt", obs_c, 1'b0);
        rst = 1'b1;
        tick();
        check("post_rst_c_gnt", obs_c, 1'b1);
        set_c(0, 0, 0, 0);
        set_l(0, 0, 0, 0);
        tick();
        tick();

        // core store then load
        set_c(1, 1, 8'h10, 8'h5A);
        tick();
        set_c(1, 0, 8'h10, 0);
        tick();
        set_c(0, 0, 0, 0);
        check("st_ld_rvalid", c_rvalid, 1'b1);
        check("st_ld_rdata", c_rdata, 8'h5A);
        tick();

        // both requesting continuously: bursts of MB
        set_c(1, 0, 8'h03, 0);
        set_l(1, 0, 8'h04, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("burst_pat_c", obs_c, pat_c[i]);
            check("burst_pat_l", obs_l, !pat_c[i]);
        end
        set_c(0, 0, 0, 0);
        set_l(0, 0, 0, 0);
        tick();

        // loader fills 0x80..0x8F, then core reads one back
        for (int i = 0; i < 16; i++) begin
            set_l(1, 1, 8'h80 + i, i);
            tick();
            check("ldr_stream_gnt", obs_l, 1'b1);
        end
        set_l(0, 0, 0, 0);
        set_c(1, 0, 8'h85, 0);
        tick();
        set_c(0, 0, 0, 0);
        check("ldr_rb_rdata", c_rdata, 8'h05);
        tick();

        // simultaneous from idle: core wins
        set_c(1, 1, 8'h21, 8'h33);
        set_l(1, 1, 8'h42, 8'h44);
        tick();
        check("tie_c", obs_c, 1'b1);
        set_c(0, 0, 0, 0);
        tick();
        set_l(0, 0, 0, 0);
        tick();

        // reset in the cycle after a load grant drops the response
        set_c(1, 0, 8'h10, 0);
        tick();
        set_c(0, 0, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_drop_rvalid", c_rvalid, 1'b0);
        check("rst_drop_rdata", c_rdata, 8'h00);
        tick();

        // random traffic; requests held until granted
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(63) != 0);
            if (!c_req && $urandom_range(9) < 6)
                set_c(1, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
            if (!l_req && $urandom_range(9) < 6)
                set_l(1, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
            tick();
            if (obs_c) c_req = 1'b0;
            if (obs_l) l_req = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
